// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: a valid/ready command stream becomes
// one AXI-Lite read or write, and each command gets exactly one response.
module axil_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [1:0] RESP_ALIGN = 2'b10;

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] wdata, wdata_n;
  logic [STRB_WIDTH-1:0] wstrb, wstrb_n;
  logic                  we, we_n;
  logic                  aw_done, aw_done_n, w_done, w_done_n;
  logic                  awvalid_n, wvalid_n, arvalid_n, bready_n, rready_n;
  logic                  rsp_valid_n;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic [1:0]            resp_n;
  logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs  = m_axil_wvalid  && m_axil_wready;
  assign ar_hs = m_axil_arvalid && m_axil_arready;
  assign b_hs  = m_axil_bvalid  && m_axil_bready;
  assign r_hs  = m_axil_rvalid  && m_axil_rready;

  // Bus payloads come straight from the command latches, which only change in IDLE.
  assign m_axil_awaddr = addr;
  assign m_axil_araddr = addr;
  assign m_axil_wdata  = wdata;
  assign m_axil_wstrb  = wstrb;
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign rsp_we        = we;

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    wdata_n     = wdata;
    wstrb_n     = wstrb;
    we_n        = we;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    awvalid_n   = m_axil_awvalid;
    wvalid_n    = m_axil_wvalid;
    arvalid_n   = m_axil_arvalid;
    bready_n    = m_axil_bready;
    rready_n    = m_axil_rready;
    rsp_valid_n = rsp_valid;
    rdata_n     = rsp_rdata;
    resp_n      = rsp_resp;
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        addr_n    = cmd_addr;
        wdata_n   = cmd_wdata;
        wstrb_n   = cmd_wstrb;
        we_n      = cmd_we;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        if (|(cmd_addr & ALIGN_MASK)) begin
          state_n     = RSP;
          rsp_valid_n = 1'b1;
          rdata_n     = '0;
          resp_n      = RESP_ALIGN;
        end else if (cmd_we) begin
          state_n   = WR;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
        end else begin
          state_n   = RD_ADDR;
          arvalid_n = 1'b1;
        end
      end
      WR: begin
        if (aw_hs) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (w_hs) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        // AW and W may finish in either order or together.
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end
      end
      WR_RESP: if (b_hs) begin
        bready_n    = 1'b0;
        rsp_valid_n = 1'b1;
        rdata_n     = '0;
        resp_n      = m_axil_bresp;
        state_n     = RSP;
      end
      RD_ADDR: if (ar_hs) begin
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
        state_n   = RD_DATA;
      end
      RD_DATA: if (r_hs) begin
        rready_n    = 1'b0;
        rsp_valid_n = 1'b1;
        rdata_n     = m_axil_rdata;
        resp_n      = m_axil_rresp;
        state_n     = RSP;
      end
      RSP: if (rsp_ready) begin
        rsp_valid_n = 1'b0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cmd_ready      <= 1'b1;
      addr           <= '0;
      wdata          <= '0;
      wstrb          <= '0;
      we             <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_rready  <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= '0;
    end else begin
      state          <= state_n;
      cmd_ready      <= (state_n == IDLE);
      addr           <= addr_n;
      wdata          <= wdata_n;
      wstrb          <= wstrb_n;
      we             <= we_n;
      aw_done        <= aw_done_n;
      w_done         <= w_done_n;
      m_axil_awvalid <= awvalid_n;
      m_axil_wvalid  <= wvalid_n;
      m_axil_arvalid <= arvalid_n;
      m_axil_bready  <= bready_n;
      m_axil_rready  <= rready_n;
      rsp_valid      <= rsp_valid_n;
      rsp_rdata      <= rdata_n;
      rsp_resp       <= resp_n;
    end
  end
endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: a delay-configurable AXI-Lite memory responder and a
// word-array reference model that predicts every response from the command.
module tb_axil_master;
  localparam int DW = 32, AW = 9, SW = 4;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]    m_axil_awprot, m_axil_arprot;
  logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [DW-1:0] m_axil_wdata, m_axil_rdata;
  logic [SW-1:0] m_axil_wstrb;
  logic [1:0]    m_axil_bresp, m_axil_rresp;
  logic          m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic          m_axil_rvalid, m_axil_rready;

  axil_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  int checks = 0, failures = 0;

  // Responder knobs: cycles of valid before ready, cycles before B/R valid.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  logic [DW-1:0] smem [0:127];
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_got, w_got, ar_got;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;

  assign m_axil_awready = m_axil_awvalid && !aw_got && (aw_cnt >= aw_dly);
  assign m_axil_wready  = m_axil_wvalid  && !w_got  && (w_cnt  >= w_dly);
  assign m_axil_arready = m_axil_arvalid && !ar_got && (ar_cnt >= ar_dly);

  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                               input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      m_axil_bvalid <= 1'b0; m_axil_rvalid <= 1'b0;
      m_axil_bresp <= 2'b00; m_axil_rresp <= 2'b00; m_axil_rdata <= '0;
    end else begin
      if (m_axil_awvalid && !aw_got) begin
        if (m_axil_awready) begin
          aw_got <= 1'b1; s_awaddr <= m_axil_awaddr; aw_cnt <= 0; aw_hs_n <= aw_hs_n + 1;
        end else aw_cnt <= aw_cnt + 1;
      end
      if (m_axil_wvalid && !w_got) begin
        if (m_axil_wready) begin
          w_got <= 1'b1; s_wdata <= m_axil_wdata; s_wstrb <= m_axil_wstrb; w_cnt <= 0; w_hs_n <= w_hs_n + 1;
        end else w_cnt <= w_cnt + 1;
      end
      if (m_axil_arvalid && !ar_got) begin
        if (m_axil_arready) begin
          ar_got <= 1'b1; s_araddr <= m_axil_araddr; ar_cnt <= 0; ar_hs_n <= ar_hs_n + 1;
        end else ar_cnt <= ar_cnt + 1;
      end
      if (aw_got && w_got && !m_axil_bvalid) begin
        if (b_cnt >= b_dly) begin
          m_axil_bvalid <= 1'b1; m_axil_bresp <= bresp_cfg; b_cnt <= 0;
          smem[s_awaddr[AW-1:2]] <= byte_merge(smem[s_awaddr[AW-1:2]], s_wdata, s_wstrb);
        end else b_cnt <= b_cnt + 1;
      end
      if (m_axil_bvalid && m_axil_bready) begin
        m_axil_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (ar_got && !m_axil_rvalid) begin
        if (r_cnt >= r_dly) begin
          m_axil_rvalid <= 1'b1; m_axil_rresp <= rresp_cfg; r_cnt <= 0;
          m_axil_rdata <= smem[s_araddr[AW-1:2]];
        end else r_cnt <= r_cnt + 1;
      end
      if (m_axil_rvalid && m_axil_rready) begin
        m_axil_rvalid <= 1'b0; ar_got <= 1'b0;
      end
    end
  end

  // Protocol monitor: a pending valid must hold with stable payload and drop after its handshake.
  int viol = 0, bus_act = 0;
  logic p_ok = 1'b0, p_aw, p_awhs, p_w, p_whs, p_ar, p_arhs;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_wstrb;
  always @(negedge clk) begin
    if (!rst && p_ok) begin
      if (p_aw && !p_awhs && (!m_axil_awvalid || m_axil_awaddr != p_awaddr)) viol++;
      if (p_w && !p_whs && (!m_axil_wvalid || m_axil_wdata != p_wdata || m_axil_wstrb != p_wstrb)) viol++;
      if (p_ar && !p_arhs && (!m_axil_arvalid || m_axil_araddr != p_araddr)) viol++;
      if ((p_awhs && m_axil_awvalid) || (p_whs && m_axil_wvalid) || (p_arhs && m_axil_arvalid)) viol++;
    end
    if (m_axil_awvalid || m_axil_wvalid || m_axil_arvalid) bus_act++;
    p_ok = !rst;
    p_aw = m_axil_awvalid; p_awhs = m_axil_awvalid && m_axil_awready; p_awaddr = m_axil_awaddr;
    p_w = m_axil_wvalid; p_whs = m_axil_wvalid && m_axil_wready; p_wdata = m_axil_wdata; p_wstrb = m_axil_wstrb;
    p_ar = m_axil_arvalid; p_arhs = m_axil_arvalid && m_axil_arready; p_araddr = m_axil_araddr;
  end

  logic [DW-1:0] ref_mem [0:127];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the response handshake.
  task automatic do_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int hold,
                        output logic o_we, output logic [DW-1:0] o_rd, output logic [1:0] o_resp,
                        output int lat);
    int n;
    cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("cmd_accept", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("rsp_arrive", 64'(rsp_valid), 64'd1);
    o_we = rsp_we; o_rd = rsp_rdata; o_resp = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_stable", 64'({rsp_valid, rsp_we, rsp_rdata, rsp_resp}), 64'({1'b1, o_we, o_rd, o_resp}));
      chk("cmd_ready_stall", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("cmd_ready_after_rsp", 64'({cmd_ready, rsp_valid}), 64'b10);
  endtask

  task automatic txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, input int hold, output logic [DW-1:0] got_rd,
                     output int lat);
    logic mis;
    logic [DW-1:0] e_rd, m, o_rd;
    logic [1:0] e_resp, o_resp;
    logic o_we;
    int aw0, w0, ar0, act0;
    aw0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n; act0 = bus_act;
    mis = (a % SW) != 0;
    if (mis) begin
      e_rd = '0; e_resp = 2'b10;
    end else if (we) begin
      m = '0;
      for (int b = 0; b < SW; b++) if (s[b]) m = m | (DW'(8'hFF) << (8 * b));
      ref_mem[a / SW] = (ref_mem[a / SW] & ~m) | (d & m);
      e_rd = '0; e_resp = bresp_cfg;
    end else begin
      e_rd = ref_mem[a / SW]; e_resp = rresp_cfg;
    end
    do_cmd(we, a, d, s, hold, o_we, o_rd, o_resp, lat);
    chk("rsp_we", 64'(o_we), 64'(we));
    chk("rsp_rdata", 64'(o_rd), 64'(e_rd));
    chk("rsp_resp", 64'(o_resp), 64'(e_resp));
    chk("aw_w_ar_handshakes", 64'({8'(aw_hs_n - aw0), 8'(w_hs_n - w0), 8'(ar_hs_n - ar0)}),
        64'({8'(!mis && we), 8'(!mis && we), 8'(!mis && !we)}));
    if (mis) begin
      chk("mis_latency", 64'(lat), 64'd1);
      chk("mis_no_bus", 64'(bus_act - act0), 64'd0);
    end
    got_rd = o_rd;
  endtask

  initial begin
    logic [DW-1:0] rd, wd;
    int lat, n;
    logic [AW-1:0] a;

    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_valids", 64'({rsp_valid, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                             m_axil_bready, m_axil_rready}), 64'd0);
    chk("reset_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
    chk("prot", 64'({m_axil_awprot, m_axil_arprot}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) txn(1'b1, AW'(i * 4), $urandom, 4'hF, 0, rd, lat);

    // Write then read with zero-delay responder.
    txn(1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 0, rd, lat);
    chk("wr_latency", 64'(lat), 64'd4);
    txn(1'b0, 9'h010, '0, '0, 0, rd, lat);
    chk("rd_deadbeef", 64'(rd), 64'hDEADBEEF);
    chk("rd_latency", 64'(lat), 64'd4);

    // W accepted three cycles before AW.
    aw_dly = 3; w_dly = 0;
    txn(1'b1, 9'h014, 32'h01020304, 4'hF, 0, rd, lat);
    aw_dly = 0; w_dly = 3;
    txn(1'b1, 9'h018, 32'h0A0B0C0D, 4'hF, 0, rd, lat);
    w_dly = 0;

    // Partial strobe.
    txn(1'b1, 9'h040, 32'h11223344, 4'hF, 0, rd, lat);
    txn(1'b1, 9'h040, 32'hAABBCCDD, 4'h5, 0, rd, lat);
    txn(1'b0, 9'h040, '0, '0, 0, rd, lat);
    chk("partial_strobe", 64'(rd), 64'h11BB33DD);

    // Misaligned read.
    txn(1'b0, 9'h012, '0, '0, 0, rd, lat);

    // Backpressure and error passthrough.
    rresp_cfg = 2'b11;
    txn(1'b0, 9'h010, '0, '0, 10, rd, lat);
    rresp_cfg = 2'b00; bresp_cfg = 2'b10;
    txn(1'b1, 9'h020, 32'h5A5A5A5A, 4'hF, 4, rd, lat);
    bresp_cfg = 2'b00;

    // Reset while waiting in RD_DATA.
    r_dly = 20;
    cmd_we = 1'b0; cmd_addr = 9'h010; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!m_axil_rready && n < 50) begin @(negedge clk); n++; end
    chk("reach_rd_data", 64'(m_axil_rready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_reset_outputs", 64'({m_axil_arvalid, m_axil_rready, rsp_valid, cmd_ready}), 64'b0001);
    r_dly = 0;
    wd = $urandom;
    txn(1'b1, 9'h024, wd, 4'hF, 0, rd, lat);
    txn(1'b0, 9'h024, '0, '0, 0, rd, lat);
    chk("post_reset_rd", 64'(rd), 64'(wd));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      a = AW'($urandom_range(0, 16) * 4 + (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0));
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3), rd, lat);
    end

    chk("protocol_violations", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
